// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the coordinate type used by
// the timing generator and every pixel renderer.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync windows are half-open: START is the first sync cycle, END the first after it.
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  // True when lo <= v < hi, all unsigned 10-bit.
  function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable. Exposes its next value so downstream decode
// can be registered in step with the count, and a wrap flag that is high in
// the cycle whose enabled edge returns the count to zero.
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned       Modulus  = 800,
  parameter int unsigned       Width    = COORD_W,
  parameter logic [Width-1:0]  ResetVal = Width'(Modulus - 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [Width-1:0] Last = Width'(Modulus - 1);

  logic [Width-1:0] count_q, count_d;
  logic             wrap;

  // Next-count and wrap detection.
  always_comb begin
    wrap    = en_i && (count_q == Last);
    count_d = count_q;
    if (en_i) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // Count register; reset parks on the last value so the first edge lands on zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= ResetVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;
  assign wrap_o  = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync and blank
// decode aligned with DrawX/DrawY, a frame-start strobe and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  output vga_timing_pkg::coord_t DrawX,
  output vga_timing_pkg::coord_t DrawY,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank,
  output logic                   frame_start,
  output logic [15:0]            frame_count
);

  import vga_timing_pkg::*;

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (HTotal > 1024 || VTotal > 1024) begin : gen_bad_params
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam coord_t HVis       = coord_t'(H_VISIBLE);
  localparam coord_t VVis       = coord_t'(V_VISIBLE);
  localparam coord_t HSyncStart = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HSyncEnd   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VSyncStart = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VSyncEnd   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t hc_q, hc_d, vc_q, vc_d;
  logic   h_wrap, v_wrap;

  wrap_counter #(
    .Modulus (HTotal),
    .Width   (COORD_W)
  ) u_hcnt (
    .clk_i   (vga_clk),
    .rst_i   (reset),
    .en_i    (1'b1),
    .count_o (hc_q),
    .next_o  (hc_d),
    .wrap_o  (h_wrap)
  );

  wrap_counter #(
    .Modulus (VTotal),
    .Width   (COORD_W)
  ) u_vcnt (
    .clk_i   (vga_clk),
    .rst_i   (reset),
    .en_i    (h_wrap),
    .count_o (vc_q),
    .next_o  (vc_d),
    .wrap_o  (v_wrap)
  );

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Decode the upcoming pixel so the registered outputs match DrawX/DrawY.
  // A vertical wrap means the next pixel is (0,0).
  always_comb begin
    hs_d          = ~in_span(hc_d, HSyncStart, HSyncEnd);
    vs_d          = ~in_span(vc_d, VSyncStart, VSyncEnd);
    blank_d       = (hc_d < HVis) && (vc_d < VVis);
    frame_start_d = v_wrap;
    frame_count_d = frame_count_q;
    if (v_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // Output registers.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for reset and line-level
// timing, and a shrunken instance so whole frames fit in a short run. A
// linear pixel-index model predicts every output on every cycle.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Shrunken geometry: 25 x 17 = 425 cycles per frame.
  localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3;
  localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;
  localparam int BHT = H_TOTAL;
  localparam int BVT = V_TOTAL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b = 1'b1, rst_s = 1'b1;
  logic [9:0]  bx, by, sx, sy;
  logic        bhs, bvs, bbl, bfs, shs, svs, sbl, sfs;
  logic [15:0] bfc, sfc;

  vga_timing_gen u_big (
    .vga_clk     (clk),
    .reset       (rst_b),
    .DrawX       (bx),
    .DrawY       (by),
    .hs          (bhs),
    .vs          (bvs),
    .blank       (bbl),
    .frame_start (bfs),
    .frame_count (bfc)
  );

  vga_timing_gen #(
    .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
    .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
  ) u_small (
    .vga_clk     (clk),
    .reset       (rst_s),
    .DrawX       (sx),
    .DrawY       (sy),
    .hs          (shs),
    .vs          (svs),
    .blank       (sbl),
    .frame_start (sfs),
    .frame_count (sfc)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int x, y, hs, vs, bl, fs;
  } exp_t;

  // k = rising edges since reset release (0 = in reset / not yet counted).
  function automatic exp_t model(int k, int hvis, int hfr, int hsy, int htot,
                                 int vvis, int vfr, int vsy, int vtot);
    exp_t e;
    int n;
    if (k == 0) begin
      e.x = htot - 1; e.y = vtot - 1; e.hs = 1; e.vs = 1; e.bl = 0; e.fs = 0;
    end else begin
      n    = (k - 1) % (htot * vtot);
      e.x  = n % htot;
      e.y  = n / htot;
      e.hs = (e.x >= hvis + hfr && e.x < hvis + hfr + hsy) ? 0 : 1;
      e.vs = (e.y >= vvis + vfr && e.y < vvis + vfr + vsy) ? 0 : 1;
      e.bl = (e.x < hvis && e.y < vvis) ? 1 : 0;
      e.fs = (n == 0) ? 1 : 0;
    end
    return e;
  endfunction

  int k_b = 0, fc_b = 0, k_s = 0, fc_s = 0;

  // Model time base for the full-size instance.
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      k_b = 0; fc_b = 0;
    end else begin
      k_b = k_b + 1;
      if ((k_b - 1) % (BHT * BVT) == 0) fc_b = (fc_b + 1) % 65536;
    end
  end

  // Model time base for the shrunken instance.
  always @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      k_s = 0; fc_s = 0;
    end else begin
      k_s = k_s + 1;
      if ((k_s - 1) % (SHT * SVT) == 0) fc_s = (fc_s + 1) % 65536;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    exp_t e;
    e = model(k_b, H_VISIBLE, H_FRONT, H_SYNC, BHT, V_VISIBLE, V_FRONT, V_SYNC, BVT);
    chk("big.DrawX", bx, e.x);
    chk("big.DrawY", by, e.y);
    chk("big.hs", bhs, e.hs);
    chk("big.vs", bvs, e.vs);
    chk("big.blank", bbl, e.bl);
    chk("big.frame_start", bfs, e.fs);
    chk("big.frame_count", bfc, fc_b);
    e = model(k_s, SHV, SHF, SHS, SHT, SVV, SVF, SVS, SVT);
    chk("small.DrawX", sx, e.x);
    chk("small.DrawY", sy, e.y);
    chk("small.hs", shs, e.hs);
    chk("small.vs", svs, e.vs);
    chk("small.blank", sbl, e.bl);
    chk("small.frame_start", sfs, e.fs);
    chk("small.frame_count", sfc, fc_s);
  end

  task automatic chk_big_reset(input string tag);
    chk({tag, ".DrawX"}, bx, 799);
    chk({tag, ".DrawY"}, by, 524);
    chk({tag, ".hs"}, bhs, 1);
    chk({tag, ".vs"}, bvs, 1);
    chk({tag, ".blank"}, bbl, 0);
    chk({tag, ".frame_start"}, bfs, 0);
    chk({tag, ".frame_count"}, bfc, 0);
  endtask

  task automatic chk_big_first(input string tag);
    chk({tag, ".DrawX"}, bx, 0);
    chk({tag, ".DrawY"}, by, 0);
    chk({tag, ".blank"}, bbl, 1);
    chk({tag, ".frame_start"}, bfs, 1);
    chk({tag, ".frame_count"}, bfc, 1);
  endtask

  initial begin
    int hs_low, bl_hi, hs_fall, hs_rise, bl_fall;
    int n_fs, cnt_bl, cnt_vs, bad_vs;
    int fs_t[4];
    int fs_fc[4];
    bit found;

    // Full-size instance: reset, first edge, one line.
    repeat (5) @(negedge clk);
    chk_big_reset("big.reset");
    #2 rst_b = 1'b0;
    @(negedge clk);
    chk_big_first("big.first");

    hs_low = 0; bl_hi = 0; hs_fall = -1; hs_rise = -1; bl_fall = -1;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      if (!bhs) hs_low++;
      if (bbl) bl_hi++;
      if (!bhs && hs_fall < 0) hs_fall = int'(bx);
      if (bhs && hs_fall >= 0 && hs_rise < 0) hs_rise = int'(bx);
      if (!bbl && bl_fall < 0) bl_fall = int'(bx);
    end
    chk("line.hs_low_cycles", hs_low, 96);
    chk("line.hs_fall_x", hs_fall, 656);
    chk("line.hs_rise_x", hs_rise, 752);
    chk("line.blank_high_cycles", bl_hi, 640);
    chk("line.blank_fall_x", bl_fall, 640);
    @(negedge clk);
    chk("line.next_y", by, 1);
    chk("line.next_x", bx, 0);

    // Asynchronous reset mid-line.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bx == 10'd300 && by == 10'd1) found = 1'b1;
    end
    chk("big.reach_300_1", found, 1);
    #1 rst_b = 1'b1;
    #1 chk_big_reset("big.async_reset");
    repeat (5) @(negedge clk);
    chk_big_reset("big.reset_hold");
    #2 rst_b = 1'b0;
    @(negedge clk);
    chk_big_first("big.restart");

    // Shrunken instance: three frames.
    #2 rst_s = 1'b0;
    n_fs = 0; cnt_bl = 0; cnt_vs = 0; bad_vs = 0;
    for (int c = 0; c < 3 * SHT * SVT; c++) begin
      @(negedge clk);
      if (sfs) begin
        if (n_fs < 4) begin
          fs_t[n_fs] = c;
          fs_fc[n_fs] = int'(sfc);
        end
        n_fs++;
      end
      if (c < SHT * SVT) begin
        if (sbl) cnt_bl++;
        if (!svs) begin
          cnt_vs++;
          if (!(sy == 10'd12 || sy == 10'd13)) bad_vs++;
        end
      end
    end
    chk("frame.fs_count", n_fs, 3);
    if (n_fs >= 3) begin
      chk("frame.fs0_time", fs_t[0], 0);
      chk("frame.fs1_time", fs_t[1], 425);
      chk("frame.fs2_time", fs_t[2], 850);
      chk("frame.fc0", fs_fc[0], 1);
      chk("frame.fc1", fs_fc[1], 2);
      chk("frame.fc2", fs_fc[2], 3);
    end
    chk("frame.blank_high_cycles", cnt_bl, 160);
    chk("frame.vs_low_cycles", cnt_vs, 50);
    chk("frame.vs_low_outside_window", bad_vs, 0);

    // Frame counter wrap from 0xFFFF.
    repeat (11) @(negedge clk);
    #1 force u_small.frame_count_q = 16'hFFFF;
    fc_s = 16'hFFFF;
    #1 release u_small.frame_count_q;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (sfs) found = 1'b1;
    end
    chk("wrap.fs_seen", found, 1);
    chk("wrap.frame_count", sfc, 0);

    // Asynchronous reset mid-frame on the shrunken instance, then two frames.
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (sx == 10'd10 && sy == 10'd8) found = 1'b1;
    end
    chk("small.reach_10_8", found, 1);
    #1 rst_s = 1'b1;
    #1;
    chk("small.async.DrawX", sx, 24);
    chk("small.async.DrawY", sy, 16);
    chk("small.async.frame_count", sfc, 0);
    repeat (5) @(negedge clk);
    #2 rst_s = 1'b0;
    n_fs = 0;
    for (int i = 0; i < 2 * SHT * SVT; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("small.restart.DrawX", sx, 0);
        chk("small.restart.frame_count", sfc, 1);
      end
      if (sfs) n_fs++;
    end
    chk("small.two_frames_fs", n_fs, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
